sym_seq_tx: RTL and testbench
=============================

SYM_SEQ_TX -- requirements
Module: sym_seq_tx

Interface
REQ-001 Parameter DEPTH, default 8: symbol buffer entries, power of two, 2..16.
REQ-002 Parameter SYM_W, default 2: symbol width in bits.
REQ-003 Parameter HOLD, default 2: clock cycles each symbol is driven, 1..15.
REQ-004 Parameter IDLE_SYM, default 0: value driven on Inp when not running.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 wr_en  in  1  append wr_data to buffer.
REQ-008 wr_data  in  SYM_W  symbol to append.
REQ-009 clear  in  1  empty buffer and abort any run.
REQ-010 start  in  1  begin playback.
REQ-011 rpt  in  4  extra full passes after the first (0 = play once); sampled at start.
REQ-012 Inp  out  SYM_W  registered symbol stream to the consumer FSM.
REQ-013 sym_valid  out  1  high while Inp carries a buffered symbol.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  sticky level; playback completed.
REQ-016 full / empty  out  1 each  buffer status.
REQ-017 level  out  clog2(DEPTH)+1  stored symbol count.
REQ-018 ovf  out  1  sticky; write attempted while full.

Function
REQ-019 FSM states IDLE, RUN, DONE; encoding 2 bits.
REQ-020 IDLE/DONE: wr_en with !full stores wr_data at wr_ptr, level+1; wr_en with full is dropped and sets ovf.
REQ-021 wr_en in RUN is ignored; buffer and level unchanged, ovf unchanged.
REQ-022 start in IDLE or DONE with level>0: next edge enters RUN, rd_ptr=0, pass count latched from rpt, done cleared, Inp=buf[0], sym_valid=1 (latency 1 cycle).
REQ-023 start with level=0: ignored, state unchanged, done unchanged.
REQ-024 start in RUN: ignored.
REQ-025 RUN: each symbol held exactly HOLD cycles via hold counter; on expiry rd_ptr advances.
REQ-026 After symbol level-1 expires: if pass count>0, rd_ptr wraps to 0, pass count-1, no gap cycle; else enter DONE.
REQ-027 Total RUN duration = level*HOLD*(rpt+1) cycles.
REQ-028 DONE: done=1, busy=0, sym_valid=0, Inp=IDLE_SYM; buffer contents retained for replay.
REQ-029 clear (any state): next edge buffer empty, level=0, ovf=0, done=0, state IDLE, Inp=IDLE_SYM; clear has priority over start and wr_en in the same cycle.
REQ-030 Simultaneous start and wr_en in IDLE/DONE: write completes, RUN uses the post-write level.
REQ-031 Pointers wrap modulo DEPTH; full when level=DEPTH, empty when level=0.

Reset
REQ-032 reset=0 asynchronously forces IDLE, pointers/level/hold/pass counters 0, Inp=IDLE_SYM, sym_valid=0, busy=0, done=0, ovf=0, empty=1, full=0.
REQ-033 Reset mid-RUN aborts immediately; buffer contents need not be preserved.
REQ-034 Deassertion takes effect at the first rising clk edge with reset=1.

Structure
REQ-035 Shared package sym_seq_pkg: state encodings (ST_IDLE, ST_RUN, ST_DONE), SYM_W default, HOLD max.
REQ-036 One sub-module sym_buf: DEPTH x SYM_W register array with write port, read address, level/full/empty.
REQ-037 FSM, hold counter, pass counter reside in sym_seq_tx.

Verification
REQ-038 Write 1,1,1,1; start, rpt=0, HOLD=2 -> Inp=1 with sym_valid for 8 cycles starting 1 cycle after start, then done=1, Inp=0.
REQ-039 Write 0,1,2,3; rpt=2 -> sequence 0,1,2,3 x3, each held 2 cycles, 24 busy cycles, no gap at wrap.
REQ-040 Write 9 symbols into DEPTH=8 -> full=1 after 8th, ovf=1, level=8, 9th symbol absent on replay.
REQ-041 start with empty buffer -> busy stays 0, done stays 0; wr_en during RUN -> level unchanged.
REQ-042 clear on 3rd symbol of run -> next cycle IDLE, busy=0, Inp=0, level=0, done=0.
REQ-043 reset=0 mid-RUN, asynchronous to clk -> outputs at reset values before next edge; restart after load works.

Source files
------------

// File: rtl/sym_seq_pkg.sv
// Shared definitions for the symbol sequence transmitter: FSM state encoding
// and the widths of the hold and pass counters.
package sym_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SYM_W_DEF  = 2;
   localparam int HOLD_MAX   = 15;
   localparam int HOLD_CNT_W = 4;
   localparam int PASS_W     = 4;

endpackage

// File: rtl/sym_seq_tx_buf.sv
// Symbol buffer: DEPTH x SYM_W register array with an append-only write port,
// a combinational read port, and occupancy status.
module sym_buf #(
   parameter int DEPTH = 8,
   parameter int SYM_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [SYM_W-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [SYM_W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [SYM_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;

   // The buffer is never drained by playback, so level only grows until a
   // clear; the write pointer wraps naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         level  <= '0;
      end else if (wr_en && !full) begin
         mem[wr_ptr] <= wr_data;
         wr_ptr      <= wr_ptr + AW'(1);
         level       <= level + LW'(1);
      end
   end

   assign rd_data = mem[rd_addr];
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);

endmodule

// File: rtl/sym_seq_tx.sv
// Symbol sequence transmitter: loads symbols into a buffer, then replays them
// on Inp, each held HOLD cycles, for rpt+1 complete passes.
module sym_seq_tx
   import sym_seq_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int SYM_W    = SYM_W_DEF,
   parameter int HOLD     = 2,
   parameter int IDLE_SYM = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [SYM_W-1:0]         wr_data,
   input  logic                     clear,
   input  logic                     start,
   input  logic [3:0]               rpt,
   output logic [SYM_W-1:0]         Inp,
   output logic                     sym_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [SYM_W-1:0]      IDLE_VAL  = SYM_W'(IDLE_SYM);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD - 1);

   state_t                 state_q, state_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [HOLD_CNT_W-1:0]  hold_q, hold_d;
   logic [PASS_W-1:0]      pass_q, pass_d;
   logic [SYM_W-1:0]       inp_d;
   logic                   valid_d;
   logic                   done_d;
   logic                   ovf_d;

   logic                   buf_wr;
   logic [AW-1:0]          rd_addr;
   logic [SYM_W-1:0]       rd_data;
   logic                   hold_expired;
   logic                   last_sym;

   sym_buf #(
      .DEPTH (DEPTH),
      .SYM_W (SYM_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .wr_en   (buf_wr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   assign hold_expired = (hold_q == HOLD_LAST);
   assign last_sym     = ({1'b0, rd_ptr_q} == (level - LW'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // rd_addr always points at the symbol that Inp will show after this edge,
   // so the single read port serves start, advance and wrap alike.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      hold_d   = hold_q;
      pass_d   = pass_q;
      inp_d    = Inp;
      valid_d  = sym_valid;
      done_d   = done;
      ovf_d    = ovf;
      buf_wr   = 1'b0;
      rd_addr  = rd_ptr_q;

      if (clear) begin
         state_d  = ST_IDLE;
         rd_ptr_d = '0;
         hold_d   = '0;
         pass_d   = '0;
         inp_d    = IDLE_VAL;
         valid_d  = 1'b0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (wr_en) begin
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     buf_wr = 1'b1;
                  end
               end
               // A write landing in the same cycle counts toward the run; if the
               // buffer was empty that write is entry 0, so bypass the array.
               if (start && (!empty || buf_wr)) begin
                  state_d  = ST_RUN;
                  rd_ptr_d = '0;
                  hold_d   = '0;
                  pass_d   = rpt;
                  done_d   = 1'b0;
                  valid_d  = 1'b1;
                  rd_addr  = '0;
                  inp_d    = empty ? wr_data : rd_data;
               end
            end

            ST_RUN: begin
               if (!hold_expired) begin
                  hold_d = hold_q + HOLD_CNT_W'(1);
               end else begin
                  hold_d = '0;
                  if (!last_sym) begin
                     rd_ptr_d = rd_ptr_q + AW'(1);
                     rd_addr  = rd_ptr_d;
                     inp_d    = rd_data;
                  end else if (pass_q != '0) begin
                     pass_d   = pass_q - PASS_W'(1);
                     rd_ptr_d = '0;
                     rd_addr  = '0;
                     inp_d    = rd_data;
                  end else begin
                     state_d = ST_DONE;
                     inp_d   = IDLE_VAL;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               inp_d   = IDLE_VAL;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= '0;
         hold_q    <= '0;
         pass_q    <= '0;
         Inp       <= IDLE_VAL;
         sym_valid <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         hold_q    <= hold_d;
         pass_q    <= pass_d;
         Inp       <= inp_d;
         sym_valid <= valid_d;
         done      <= done_d;
         ovf       <= ovf_d;
      end
   end

   assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_sym_seq_tx.sv
// Self-checking bench for sym_seq_tx: a vector table, directed corner
// sequences and random traffic, all compared against a queue-based model.
module tb_sym_seq_tx;

   localparam int DEPTH    = 8;
   localparam int SYM_W    = 2;
   localparam int HOLD     = 2;
   localparam int IDLE_SYM = 0;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             wr_en = 1'b0;
   logic [SYM_W-1:0] wr_data = '0;
   logic             clear = 1'b0;
   logic             start = 1'b0;
   logic [3:0]       rpt = '0;

   logic [SYM_W-1:0] Inp;
   logic             sym_valid, busy, done, full, empty, ovf;
   logic [3:0]       level;

   int checks = 0;
   int failures = 0;

   sym_seq_tx #(
      .DEPTH    (DEPTH),
      .SYM_W    (SYM_W),
      .HOLD     (HOLD),
      .IDLE_SYM (IDLE_SYM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clear     (clear),
      .start     (start),
      .rpt       (rpt),
      .Inp       (Inp),
      .sym_valid (sym_valid),
      .busy      (busy),
      .done      (done),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Packed view: {Inp, sym_valid, busy, done, full, empty, level, ovf}
   logic [11:0] dut_vec;
   assign dut_vec = {Inp, sym_valid, busy, done, full, empty, level, ovf};
   localparam logic [11:0] RESET_VEC = 12'h020;

   // Reference model: stored symbols plus the remaining playback stream,
   // one queue entry per cycle the stream still has to drive.
   logic [SYM_W-1:0] m_buf[$];
   logic [SYM_W-1:0] m_stream[$];
   logic             m_done;
   logic             m_ovf;

   task automatic model_reset();
      m_buf.delete();
      m_stream.delete();
      m_done = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_step();
      if (clear) begin
         model_reset();
      end else if (m_stream.size() > 0) begin
         void'(m_stream.pop_front());
         if (m_stream.size() == 0) m_done = 1'b1;
      end else begin
         if (wr_en) begin
            if (m_buf.size() < DEPTH) m_buf.push_back(wr_data);
            else m_ovf = 1'b1;
         end
         if (start && m_buf.size() > 0) begin
            for (int p = 0; p <= int'(rpt); p++)
               for (int i = 0; i < m_buf.size(); i++)
                  for (int h = 0; h < HOLD; h++)
                     m_stream.push_back(m_buf[i]);
            m_done = 1'b0;
         end
      end
   endtask

   function automatic logic [11:0] model_vec();
      logic [SYM_W-1:0] inp;
      logic             run;
      int               n;
      run = (m_stream.size() > 0);
      inp = run ? m_stream[0] : SYM_W'(IDLE_SYM);
      n   = m_buf.size();
      return {inp, run, run, m_done, (n == DEPTH), (n == 0), 4'(n), m_ovf};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      check(name, 32'(dut_vec), 32'(model_vec()));
   endtask

   task automatic applyStimulus(input logic we, input logic [SYM_W-1:0] wd, input logic clr,
                                input logic st, input logic [3:0] r);
      wr_en   = we;
      wr_data = wd;
      clear   = clr;
      start   = st;
      rpt     = r;
      @(posedge clk);
      model_step();
      #1;
      checkOutput("model");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic write_sym(input logic [SYM_W-1:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 4'd0);
   endtask

   typedef struct {
      logic             wr_en;
      logic [SYM_W-1:0] wr_data;
      logic             clear;
      logic             start;
      logic [3:0]       rpt;
      logic [SYM_W-1:0] e_inp;
      logic             e_valid;
      logic             e_busy;
      logic             e_done;
      logic [3:0]       e_level;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic we, input logic [SYM_W-1:0] wd, input logic clr,
                          input logic st, input logic [3:0] r, input logic [SYM_W-1:0] ei,
                          input logic ev, input logic eb, input logic ed, input logic [3:0] el);
      vec_t v;
      v.wr_en = we; v.wr_data = wd; v.clear = clr; v.start = st; v.rpt = r;
      v.e_inp = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_level = el;
      vecs.push_back(v);
   endtask

   initial begin
      int busy_cnt;

      model_reset();
      @(posedge clk);
      #1;
      check("reset_state", 32'(dut_vec), 32'(RESET_VEC));
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);

      // Four 1s played once: 8 busy cycles of Inp=1, then done; wr_en mid-run is ignored.
      for (int i = 1; i <= 4; i++) add_vec(1, 2'd1, 0, 0, 4'd0, 2'd0, 0, 0, 0, 4'(i));
      add_vec(0, 2'd0, 0, 1, 4'd0, 2'd1, 1, 1, 0, 4'd4);
      for (int i = 0; i < 7; i++) add_vec(i == 2, 2'd2, 0, 0, 4'd0, 2'd1, 1, 1, 0, 4'd4);
      add_vec(0, 2'd0, 0, 0, 4'd0, 2'd0, 0, 0, 1, 4'd4);
      add_vec(0, 2'd0, 0, 1, 4'd0, 2'd1, 1, 1, 0, 4'd4);
      add_vec(0, 2'd0, 1, 0, 4'd0, 2'd0, 0, 0, 0, 4'd0);
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].wr_en, vecs[k].wr_data, vecs[k].clear, vecs[k].start, vecs[k].rpt);
         check($sformatf("vec%0d", k), {Inp, sym_valid, busy, done, level},
               {vecs[k].e_inp, vecs[k].e_valid, vecs[k].e_busy, vecs[k].e_done, vecs[k].e_level});
      end

      // 0,1,2,3 with two repeats: 24 contiguous busy cycles
      for (int i = 0; i < 4; i++) write_sym(SYM_W'(i));
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd2);
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < 40 && busy; i++) begin
         idle(1);
         if (busy) busy_cnt++;
      end
      check("rpt2_busy_cycles", 32'(busy_cnt), 32'd24);
      check("rpt2_done", 32'(done), 32'd1);

      // Overflow: ninth write dropped
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 8; i++) write_sym(SYM_W'((i * 3) % 4));
      check("full_after_8", 32'(full), 32'd1);
      write_sym(2'd3);
      check("ovf_level", {ovf, level}, {1'b1, 4'd8});
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd0);
      idle(17);

      // Start with empty buffer, then writes during a run
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd1);
      check("empty_start", {busy, done}, 2'b00);
      write_sym(2'd2);
      write_sym(2'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd0);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 4'd0);
      check("run_write_level", 32'(level), 32'd2);
      idle(4);

      // Clear on the third symbol, together with start and wr_en
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) write_sym(SYM_W'(i));
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd0);
      idle(4);
      check("third_symbol", {Inp, sym_valid}, {2'd2, 1'b1});
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 4'd0);
      check("clear_mid_run", {busy, Inp, level, done}, 8'h00);

      // Asynchronous reset mid-run, then reload and replay
      write_sym(2'd3);
      write_sym(2'd1);
      write_sym(2'd2);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd0);
      idle(3);
      #2 reset = 1'b0;
      #1;
      check("async_reset", 32'(dut_vec), 32'(RESET_VEC));
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      write_sym(2'd2);
      write_sym(2'd3);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd1);
      idle(9);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 2) == 0), SYM_W'($urandom),
                       ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                       4'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
